// File: rtl/jk_checker.sv
// -----------------------------------------------------------------------------
// jk_checker
//
// Reference-model checker for a JK flip-flop. It sits next to the DUT and
// watches the same j, k and q signals. On every clock it:
//   - predicts q (exp_q) from its own JK model,
//   - compares the DUT q against that prediction while checking is active,
//   - counts mismatches and stops checking once MAX_ERR is reached,
//   - counts how often each JK mode (hold, reset, set, toggle) is exercised.
// The result is a pass/fail and coverage verdict in hardware, with no software
// scoreboard needed.
//
// Parameters
//   CNT_W    width of the error and coverage counters (they saturate at all-ones)
//   MAX_ERR  error count at which the checker halts (1 .. 2**CNT_W-1)
//   COV_MIN  hits per mode needed for coverage closure (1 .. 2**CNT_W-1)
//
// Ports
//   clk         clock shared with the DUT; every state change is on posedge
//   rst         asynchronous active-high reset
//   j, k        JK inputs exactly as driven into the DUT
//   q           DUT output
//   en          check enable; gates comparison and coverage, never the model
//   clr         synchronous clear of counters, flags and FSM (keeps exp_q)
//   exp_q       model-predicted q
//   mismatch    one-cycle pulse per mismatching edge
//   err_sticky  set by the first mismatch, held until rst or clr
//   err_count   saturating mismatch count
//   cov_hold/cov_rst/cov_set/cov_tog  saturating per-mode hit counts
//   cov_done    registered: all four mode counts are >= COV_MIN
//   halted      high while the FSM is in HALT
// -----------------------------------------------------------------------------
module jk_checker #(
    parameter int CNT_W   = 16,
    parameter int MAX_ERR = 8,
    parameter int COV_MIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             en,
    input  logic             clr,
    output logic             exp_q,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cov_hold,
    output logic [CNT_W-1:0] cov_rst,
    output logic [CNT_W-1:0] cov_set,
    output logic [CNT_W-1:0] cov_tog,
    output logic             cov_done,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ERR_LIMIT = CNT_W'(MAX_ERR);
    localparam logic [CNT_W-1:0] COV_LIMIT = CNT_W'(COV_MIN);

    state_t           state, state_n;
    logic             mismatch_n;
    logic             err_sticky_n;
    logic [CNT_W-1:0] err_count_n;
    logic [CNT_W-1:0] cov_hold_n, cov_rst_n, cov_set_n, cov_tog_n;
    logic             cov_done_n;

    // An active edge is one where the checker was already in CHECK with en
    // high before the edge; the edge that first sees en only moves IDLE->CHECK.
    logic active;
    logic miss;

    assign active = (state == CHECK) && en;
    assign miss   = active && (q != exp_q);
    assign halted = (state == HALT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks the DUT on every edge, independent of en,
    // FSM state and clr, so it never loses sync with the flop it mirrors.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, just like the flop being modelled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   exp_q <= exp_q;
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                default: exp_q <= ~exp_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        mismatch_n   = 1'b0;
        err_sticky_n = err_sticky;
        err_count_n  = err_count;
        cov_hold_n   = cov_hold;
        cov_rst_n    = cov_rst;
        cov_set_n    = cov_set;
        cov_tog_n    = cov_tog;

        if (clr) begin
            // clr outranks en and any mismatch seen on the same edge.
            state_n      = IDLE;
            err_sticky_n = 1'b0;
            err_count_n  = '0;
            cov_hold_n   = '0;
            cov_rst_n    = '0;
            cov_set_n    = '0;
            cov_tog_n    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) state_n = CHECK;
                end
                CHECK: begin
                    if (!en) begin
                        state_n = IDLE;
                    end else begin
                        unique case ({j, k})
                            2'b00:   cov_hold_n = sat_inc(cov_hold);
                            2'b01:   cov_rst_n  = sat_inc(cov_rst);
                            2'b10:   cov_set_n  = sat_inc(cov_set);
                            default: cov_tog_n  = sat_inc(cov_tog);
                        endcase
                        if (miss) begin
                            mismatch_n   = 1'b1;
                            err_sticky_n = 1'b1;
                            err_count_n  = sat_inc(err_count);
                            // Halt on the edge whose mismatch brings the
                            // count to the limit; that mismatch still counts.
                            if (err_count_n == ERR_LIMIT) state_n = HALT;
                        end
                    end
                end
                HALT: begin
                    state_n = HALT;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // Closure is judged on the counts as they will be after this edge.
        cov_done_n = !clr &&
                     (cov_hold_n >= COV_LIMIT) && (cov_rst_n >= COV_LIMIT) &&
                     (cov_set_n  >= COV_LIMIT) && (cov_tog_n >= COV_LIMIT);
    end

    // ------------------------------------------------------------------
    // Checker state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            cov_hold   <= '0;
            cov_rst    <= '0;
            cov_set    <= '0;
            cov_tog    <= '0;
            cov_done   <= 1'b0;
        end else begin
            state      <= state_n;
            mismatch   <= mismatch_n;
            err_sticky <= err_sticky_n;
            err_count  <= err_count_n;
            cov_hold   <= cov_hold_n;
            cov_rst    <= cov_rst_n;
            cov_set    <= cov_set_n;
            cov_tog    <= cov_tog_n;
            cov_done   <= cov_done_n;
        end
    end

endmodule

// File: tb/tb_jk_checker.sv
// -----------------------------------------------------------------------------
// tb_jk_checker
//
// Directed bench for jk_checker. Two instances share all stimulus:
//   u_a  CNT_W=16, MAX_ERR=3, COV_MIN=2  (main behaviour, halt, clr)
//   u_b  CNT_W=3,  MAX_ERR=7, COV_MIN=1  (saturation, large counts under rst)
// The bench keeps its own JK value m, the q a correct flop would show, which
// is both the expected exp_q and the value driven on q for fault-free cycles.
// Inputs are driven and outputs sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_jk_checker;

    logic clk, rst, j, k, q, en, clr;

    logic        a_expq, a_mis, a_stk, a_done, a_halt;
    logic [15:0] a_err, a_hold, a_rst, a_set, a_tog;
    logic        b_expq, b_mis, b_stk, b_done, b_halt;
    logic [2:0]  b_err, b_hold, b_rst, b_set, b_tog;

    int total = 0;
    int bad   = 0;
    logic m   = 1'b0;

    jk_checker #(.CNT_W(16), .MAX_ERR(3), .COV_MIN(2)) u_a (
        .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .en(en), .clr(clr),
        .exp_q(a_expq), .mismatch(a_mis), .err_sticky(a_stk), .err_count(a_err),
        .cov_hold(a_hold), .cov_rst(a_rst), .cov_set(a_set), .cov_tog(a_tog),
        .cov_done(a_done), .halted(a_halt)
    );

    jk_checker #(.CNT_W(3), .MAX_ERR(7), .COV_MIN(1)) u_b (
        .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .en(en), .clr(clr),
        .exp_q(b_expq), .mismatch(b_mis), .err_sticky(b_stk), .err_count(b_err),
        .cov_hold(b_hold), .cov_rst(b_rst), .cov_set(b_set), .cov_tog(b_tog),
        .cov_done(b_done), .halted(b_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: wait for the edge, then advance the bench JK model with
    // the j/k that were present before the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        case ({j, k})
            2'b01:   m = 1'b0;
            2'b10:   m = 1'b1;
            2'b11:   m = ~m;
            default: m = m;
        endcase
    endtask

    task automatic drive(input logic jv, input logic kv, input logic qv);
        j = jv; k = kv; q = qv;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0;
        #12;
        m = 1'b0;
        total++;
        if ({a_expq, a_mis, a_stk, a_done, a_halt} !== 5'b0 || a_err !== 16'd0) begin
            bad++; $display("FAIL reset_flags got=%b err=%0d want=00000 err=0",
                            {a_expq, a_mis, a_stk, a_done, a_halt}, a_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if ({a_expq, a_mis, a_stk, a_done, a_halt} !== 5'b0 ||
                {a_err, a_hold, a_rst, a_set, a_tog} !== 80'd0) begin
                bad++; $display("FAIL idle_cycle%0d flags=%b err=%0d hold=%0d tog=%0d want all 0",
                                i, {a_expq, a_mis, a_stk, a_done, a_halt}, a_err, a_hold, a_tog);
            end
        end
        total++;
        if (b_hold !== 3'd0 || b_err !== 3'd0) begin
            bad++; $display("FAIL idle_small hold=%0d err=%0d want 0 0", b_hold, b_err);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sweep();
        logic [1:0] jk_l [9] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10};
        int eh = 0, er = 0, es = 0, et = 0;
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // IDLE -> CHECK only
        total++;
        if (a_hold !== 16'd0) begin
            bad++; $display("FAIL sweep_transition hold=%0d want=0", a_hold);
        end
        for (int i = 0; i < 9; i++) begin
            case (jk_l[i])
                2'b00:   eh++;
                2'b01:   er++;
                2'b10:   es++;
                default: et++;
            endcase
            drive(jk_l[i][1], jk_l[i][0], m);
            total++;
            if (a_expq !== m || a_err !== 16'd0 || a_mis !== 1'b0) begin
                bad++; $display("FAIL sweep_edge%0d expq=%b err=%0d mis=%b want expq=%b err=0 mis=0",
                                i, a_expq, a_err, a_mis, m);
            end
            total++;
            if (a_hold !== 16'(eh) || a_rst !== 16'(er) || a_set !== 16'(es) || a_tog !== 16'(et)) begin
                bad++; $display("FAIL sweep_cov%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                                i, a_hold, a_rst, a_set, a_tog, eh, er, es, et);
            end
            // Sweep leaves set at 1 until the 9th edge, which closes coverage.
            total++;
            if (a_done !== (i == 8)) begin
                bad++; $display("FAIL sweep_done%0d got=%b want=%b", i, a_done, (i == 8));
            end
        end
        en = 1'b0;
        drive(1'b0, 1'b0, m);     // CHECK -> IDLE, en low so no check
        total++;
        if (a_hold !== 16'd2) begin
            bad++; $display("FAIL sweep_endisable hold=%0d want=2", a_hold);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fault();
        clr = 1'b1; drive(1'b0, 1'b0, m); clr = 1'b0;
        total++;
        if ({a_done, a_stk, a_mis} !== 3'b0 || {a_err, a_hold, a_rst, a_set, a_tog} !== 80'd0) begin
            bad++; $display("FAIL fault_clr done/stk/mis=%b err=%0d hold=%0d want 0",
                            {a_done, a_stk, a_mis}, a_err, a_hold);
        end
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // transition
        drive(1'b1, 1'b0, m);     // set, correct q
        drive(1'b0, 1'b0, 1'b0);  // DUT should show 1: forced 0
        total++;
        if (a_mis !== 1'b1 || a_stk !== 1'b1 || a_err !== 16'd1) begin
            bad++; $display("FAIL fault_detect mis=%b stk=%b err=%0d want 1 1 1", a_mis, a_stk, a_err);
        end
        drive(1'b0, 1'b0, m);
        total++;
        if (a_mis !== 1'b0 || a_stk !== 1'b1 || a_err !== 16'd1) begin
            bad++; $display("FAIL fault_after mis=%b stk=%b err=%0d want 0 1 1", a_mis, a_stk, a_err);
        end
        en = 1'b0;
        drive(1'b0, 1'b0, m);
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        int ecnt = 0, tcnt = 0;
        logic hl = 1'b0, act, mism;
        clr = 1'b1; drive(1'b0, 1'b0, m); clr = 1'b0;
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // transition
        for (int i = 0; i < 18; i++) begin
            act  = !hl;
            mism = act && (m != 1'b0);
            if (act) tcnt++;
            drive(1'b1, 1'b1, 1'b0);   // q stuck at 0 while toggling
            if (mism) ecnt++;
            hl = (ecnt == 3);
            total++;
            if (a_err !== 16'(ecnt) || a_mis !== mism || a_halt !== hl ||
                a_expq !== m || a_tog !== 16'(tcnt)) begin
                bad++; $display("FAIL halt_edge%0d err=%0d mis=%b halt=%b expq=%b tog=%0d want %0d %b %b %b %0d",
                                i, a_err, a_mis, a_halt, a_expq, a_tog, ecnt, mism, hl, m, tcnt);
            end
        end
        en = 1'b0;
        drive(1'b0, 1'b0, m);
        total++;
        if (a_halt !== 1'b1 || a_err !== 16'd3) begin
            bad++; $display("FAIL halt_hold halt=%b err=%0d want 1 3", a_halt, a_err);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clr_vs_mismatch();
        int ecnt = 0;
        clr = 1'b1; drive(1'b0, 1'b0, m); clr = 1'b0;
        total++;
        if (a_halt !== 1'b0 || a_err !== 16'd0) begin
            bad++; $display("FAIL clr_unhalt halt=%b err=%0d want 0 0", a_halt, a_err);
        end
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // transition
        for (int i = 0; i < 8 && ecnt < 2; i++) begin
            if (m) ecnt++;
            drive(1'b1, 1'b1, 1'b0);
        end
        if (!m) drive(1'b1, 1'b0, m);   // correct set so the next edge mismatches
        total++;
        if (a_err !== 16'd2) begin
            bad++; $display("FAIL clr_precond err=%0d want=2", a_err);
        end
        clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0);  // mismatching edge with clr
        clr = 1'b0;
        total++;
        if ({a_mis, a_stk, a_done, a_halt} !== 4'b0 ||
            {a_err, a_hold, a_rst, a_set, a_tog} !== 80'd0 || a_expq !== m) begin
            bad++; $display("FAIL clr_priority mis/stk/done/halt=%b err=%0d tog=%0d expq=%b want 0000 0 0 %b",
                            {a_mis, a_stk, a_done, a_halt}, a_err, a_tog, a_expq, m);
        end
        // en still high: this edge must only leave IDLE, proving clr went to IDLE.
        drive(1'b1, 1'b1, m);
        total++;
        if (a_tog !== 16'd0 || a_err !== 16'd0) begin
            bad++; $display("FAIL clr_idle tog=%0d err=%0d want 0 0", a_tog, a_err);
        end
        en = 1'b0;
        drive(1'b0, 1'b0, m);
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        clr = 1'b1; drive(1'b0, 1'b0, m); clr = 1'b0;
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // transition
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, ~m);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, m);
        total++;
        if (b_err !== 3'd5 || b_tog !== 3'd7) begin
            bad++; $display("FAIL async_precond err=%0d tog=%0d want 5 7", b_err, b_tog);
        end
        #2 rst = 1'b1;
        #1;
        m = 1'b0;
        total++;
        if ({b_expq, b_mis, b_stk, b_done, b_halt} !== 5'b0 ||
            {b_err, b_hold, b_rst, b_set, b_tog} !== 15'd0) begin
            bad++; $display("FAIL async_small flags=%b err=%0d tog=%0d want all 0",
                            {b_expq, b_mis, b_stk, b_done, b_halt}, b_err, b_tog);
        end
        total++;
        if ({a_expq, a_mis, a_stk, a_done, a_halt} !== 5'b0 ||
            {a_err, a_hold, a_rst, a_set, a_tog} !== 80'd0) begin
            bad++; $display("FAIL async_main flags=%b err=%0d tog=%0d want all 0",
                            {a_expq, a_mis, a_stk, a_done, a_halt}, a_err, a_tog);
        end
        en = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0;
        #1 rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturation();
        en = 1'b1;
        drive(1'b0, 1'b0, m);     // transition
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b0, m);
            total++;
            if (b_hold !== ((i > 7) ? 3'd7 : 3'(i))) begin
                bad++; $display("FAIL sat_hold%0d got=%0d want=%0d", i, b_hold, (i > 7) ? 7 : i);
            end
        end
        total++;
        if (a_hold !== 16'd9 || b_err !== 3'd0) begin
            bad++; $display("FAIL sat_wide hold=%0d small_err=%0d want 9 0", a_hold, b_err);
        end
        en = 1'b0;
        drive(1'b0, 1'b0, m);
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_sweep();
        test_fault();
        test_halt();
        test_clr_vs_mismatch();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
